// File: rtl/icap_pkg.sv
// Shared ICAP packet constants, header field helpers and responder state encoding.
package icap_pkg;

  localparam logic [15:0] SyncWord0 = 16'hAA99;
  localparam logic [15:0] SyncWord1 = 16'h5566;
  localparam logic [15:0] NoopWord  = 16'h2000;

  localparam logic [2:0] HdrType1 = 3'b001;

  localparam logic [1:0] OpNoop  = 2'b00;
  localparam logic [1:0] OpRead  = 2'b01;
  localparam logic [1:0] OpWrite = 2'b10;

  localparam logic [5:0] RegCmd  = 6'h05;
  localparam logic [5:0] RegGen1 = 6'h13;
  localparam logic [5:0] RegGen2 = 6'h14;
  localparam logic [5:0] RegGen5 = 6'h17;

  localparam logic [15:0] CmdReboot = 16'h000E;
  localparam logic [15:0] CmdDesync = 16'h000D;

  typedef enum logic [2:0] {
    StUnsync,
    StSync1,
    StHdr,
    StWdata,
    StRwait,
    StRbusy,
    StRdone
  } icap_state_e;

  function automatic logic [2:0] hdr_type(input logic [15:0] w);
    return w[15:13];
  endfunction

  function automatic logic [1:0] hdr_op(input logic [15:0] w);
    return w[12:11];
  endfunction

  function automatic logic [5:0] hdr_reg(input logic [15:0] w);
    return w[10:5];
  endfunction

  function automatic logic [4:0] hdr_cnt(input logic [15:0] w);
    return w[4:0];
  endfunction

endpackage

// File: rtl/icap_bitswap.sv
// Per-byte bit mirror between the physical ICAP bus order and logical word order.
module icap_bitswap (
  input  logic [15:0] i_word,
  output logic [15:0] o_word
);

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign o_word[i]     = i_word[7-i];
    assign o_word[8+i]   = i_word[15-i];
  end

endmodule

// File: rtl/icap_responder.sv
// ICAP packet-port stand-in: sync detection, type-1 packet decode, GENERAL_1/2/5 storage,
// busy-handshaked readback and REBOOT signalling with the latched boot address.
module icap_responder
  import icap_pkg::*;
#(
  parameter int unsigned BUSY_CYCLES = 2,
  parameter logic [15:0] GEN5_INIT   = 16'h0000
) (
  input  logic        clk_16M00,
  input  logic        reset,
  input  logic        ce,
  input  logic        write,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        busy,
  output logic        synced,
  output logic        reboot,
  output logic [23:0] boot_addr,
  output logic [15:0] gen5,
  output logic        error
);

  icap_state_e r_state, w_state_d;
  logic [15:0] r_gen1, w_gen1_d;
  logic [15:0] r_gen2, w_gen2_d;
  logic [15:0] r_gen5, w_gen5_d;
  logic [15:0] r_dout, w_dout_d;
  logic        r_busy, w_busy_d;
  logic        r_synced, w_synced_d;
  logic        r_reboot, w_reboot_d;
  logic        r_error, w_error_d;
  logic [5:0]  r_reg, w_reg_d;
  logic [4:0]  r_cnt, w_cnt_d;
  logic [3:0]  r_bcnt, w_bcnt_d;
  logic        r_prev_ce_lo, r_prev_write;

  logic [15:0] w_din;
  logic [15:0] w_rd_val;
  logic        w_wr_word, w_rd_cyc, w_abort;

  icap_bitswap u_din_swap (
    .i_word(din),
    .o_word(w_din)
  );

  // r_dout holds the logical word; the bus sees it mirrored.
  icap_bitswap u_dout_swap (
    .i_word(r_dout),
    .o_word(dout)
  );

  assign w_wr_word = ~ce & ~write;
  assign w_rd_cyc  = ~ce & write;
  assign w_abort   = r_prev_ce_lo & ~ce & (write != r_prev_write);

  assign busy      = r_busy;
  assign synced    = r_synced;
  assign reboot    = r_reboot;
  assign error     = r_error;
  assign gen5      = r_gen5;
  assign boot_addr = {r_gen2[7:0], r_gen1};

  always_comb begin
    w_rd_val = 16'h0000;
    case (r_reg)
      RegGen1: w_rd_val = r_gen1;
      RegGen2: w_rd_val = r_gen2;
      RegGen5: w_rd_val = r_gen5;
      default: w_rd_val = 16'h0000;
    endcase
  end

  always_comb begin
    w_state_d  = r_state;
    w_gen1_d   = r_gen1;
    w_gen2_d   = r_gen2;
    w_gen5_d   = r_gen5;
    w_dout_d   = r_dout;
    w_busy_d   = r_busy;
    w_synced_d = r_synced;
    w_reboot_d = 1'b0;
    w_error_d  = 1'b0;
    w_reg_d    = r_reg;
    w_cnt_d    = r_cnt;
    w_bcnt_d   = r_bcnt;

    if (w_abort) begin
      w_error_d  = 1'b1;
      w_synced_d = 1'b0;
      w_busy_d   = 1'b0;
      w_state_d  = StUnsync;
    end else begin
      unique case (r_state)
        StUnsync: begin
          if (w_wr_word && w_din == SyncWord0) w_state_d = StSync1;
        end
        StSync1: begin
          if (w_wr_word) begin
            if (w_din == SyncWord1) begin
              w_state_d  = StHdr;
              w_synced_d = 1'b1;
            end else if (w_din != SyncWord0) begin
              w_state_d = StUnsync;
            end
          end
        end
        StHdr, StRdone: begin
          if (w_wr_word) begin
            w_state_d = StHdr;
            w_reg_d   = hdr_reg(w_din);
            w_cnt_d   = hdr_cnt(w_din);
            if (hdr_type(w_din) != HdrType1) begin
              w_error_d = 1'b1;
            end else begin
              case (hdr_op(w_din))
                OpNoop:  w_state_d = StHdr;
                OpWrite: if (hdr_cnt(w_din) != 5'd0) w_state_d = StWdata;
                OpRead:  if (hdr_cnt(w_din) != 5'd0) w_state_d = StRwait;
                default: w_error_d = 1'b1;
              endcase
            end
          end
        end
        StWdata: begin
          if (w_wr_word) begin
            w_cnt_d = r_cnt - 5'd1;
            if (r_cnt == 5'd1) w_state_d = StHdr;
            case (r_reg)
              RegGen1: w_gen1_d = w_din;
              RegGen2: w_gen2_d = w_din;
              RegGen5: w_gen5_d = w_din;
              RegCmd: begin
                if (w_din == CmdReboot) begin
                  w_reboot_d = 1'b1;
                  w_synced_d = 1'b0;
                  w_state_d  = StUnsync;
                end else if (w_din == CmdDesync) begin
                  w_synced_d = 1'b0;
                  w_state_d  = StUnsync;
                end
              end
              default: ;
            endcase
          end
        end
        StRwait: begin
          if (w_rd_cyc) begin
            w_state_d = StRbusy;
            w_busy_d  = 1'b1;
            w_bcnt_d  = 4'(BUSY_CYCLES);
          end
        end
        StRbusy: begin
          // CE-high cycles simply hold the busy countdown.
          if (w_rd_cyc) begin
            if (r_bcnt == 4'd1) begin
              w_dout_d  = w_rd_val;
              w_busy_d  = 1'b0;
              w_cnt_d   = r_cnt - 5'd1;
              w_state_d = (r_cnt == 5'd1) ? StRdone : StRwait;
            end else begin
              w_bcnt_d = r_bcnt - 4'd1;
            end
          end
        end
        default: w_state_d = StUnsync;
      endcase
    end
  end

  always_ff @(posedge clk_16M00 or posedge reset) begin
    if (reset) begin
      r_state      <= StUnsync;
      r_gen1       <= 16'h0000;
      r_gen2       <= 16'h0000;
      r_gen5       <= GEN5_INIT;
      r_dout       <= 16'hFFFF;
      r_busy       <= 1'b0;
      r_synced     <= 1'b0;
      r_reboot     <= 1'b0;
      r_error      <= 1'b0;
      r_reg        <= 6'd0;
      r_cnt        <= 5'd0;
      r_bcnt       <= 4'd0;
      r_prev_ce_lo <= 1'b0;
      r_prev_write <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_gen1       <= w_gen1_d;
      r_gen2       <= w_gen2_d;
      r_gen5       <= w_gen5_d;
      r_dout       <= w_dout_d;
      r_busy       <= w_busy_d;
      r_synced     <= w_synced_d;
      r_reboot     <= w_reboot_d;
      r_error      <= w_error_d;
      r_reg        <= w_reg_d;
      r_cnt        <= w_cnt_d;
      r_bcnt       <= w_bcnt_d;
      r_prev_ce_lo <= ~ce;
      r_prev_write <= write;
    end
  end

endmodule

// File: tb/tb_icap_responder.sv
// Bench for icap_responder: directed multiboot/readback/abort/retention scenarios followed by
// randomized packet traffic checked against a register-level model of the ICAP port.
module tb_icap_responder;

  localparam int unsigned BusyCycles = 2;
  localparam logic [15:0] Gen5Init   = 16'h00A5;

  logic        clk_16M00 = 1'b0;
  logic        reset;
  logic        ce;
  logic        write;
  logic [15:0] din;
  logic [15:0] dout;
  logic        busy;
  logic        synced;
  logic        reboot;
  logic [23:0] boot_addr;
  logic [15:0] gen5;
  logic        error;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Register-level model state
  logic [15:0] m_gen1, m_gen2, m_gen5;
  logic        m_synced;

  icap_responder #(
    .BUSY_CYCLES(BusyCycles),
    .GEN5_INIT  (Gen5Init)
  ) u_dut (
    .clk_16M00(clk_16M00),
    .reset    (reset),
    .ce       (ce),
    .write    (write),
    .din      (din),
    .dout     (dout),
    .busy     (busy),
    .synced   (synced),
    .reboot   (reboot),
    .boot_addr(boot_addr),
    .gen5     (gen5),
    .error    (error)
  );

  always #5 clk_16M00 = ~clk_16M00;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] swap16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i]   = v[7-i];
      r[8+i] = v[15-i];
    end
    return r;
  endfunction

  function automatic logic [15:0] hdr(input logic [1:0] op, input logic [5:0] rg,
                                      input logic [4:0] cnt);
    return {3'b001, op, rg, cnt};
  endfunction

  function automatic logic [15:0] model_read(input logic [5:0] rg);
    if (rg == 6'h13) return m_gen1;
    if (rg == 6'h14) return m_gen2;
    if (rg == 6'h17) return m_gen5;
    return 16'h0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One bus cycle; returns 1ns after the sampling edge.
  task automatic drive(input logic c, input logic w, input logic [15:0] v);
    @(negedge clk_16M00);
    ce    = c;
    write = w;
    din   = swap16(v);
    @(posedge clk_16M00);
    #1;
  endtask

  task automatic wr(input logic [15:0] v);
    drive(1'b0, 1'b0, v);
  endtask

  task automatic idle_w();
    drive(1'b1, 1'b0, 16'($urandom));
  endtask

  task automatic idle_r();
    drive(1'b1, 1'b1, 16'($urandom));
  endtask

  task automatic model_reset();
    m_gen1   = 16'h0000;
    m_gen2   = 16'h0000;
    m_gen5   = Gen5Init;
    m_synced = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_16M00);
    reset = 1'b1;
    ce    = 1'b1;
    write = 1'b0;
    @(posedge clk_16M00);
    #1;
    @(negedge clk_16M00);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic do_sync();
    wr(16'hAA99);
    wr(16'h5566);
    m_synced = 1'b1;
    check("sync", synced, m_synced);
  endtask

  task automatic write_pkt(input logic [5:0] rg, input int unsigned cnt);
    logic [15:0] d;
    wr(hdr(2'b10, rg, 5'(cnt)));
    for (int i = 0; i < int'(cnt); i++) begin
      d = 16'($urandom);
      if ($urandom_range(0, 3) == 0) idle_w();
      wr(d);
      if (rg == 6'h13) m_gen1 = d;
      if (rg == 6'h14) m_gen2 = d;
      if (rg == 6'h17) m_gen5 = d;
    end
    check("wr_gen5", gen5, m_gen5);
    check("wr_boot_addr", boot_addr, {m_gen2[7:0], m_gen1});
    check("wr_synced", synced, m_synced);
  endtask

  task automatic read_pkt(input logic [5:0] rg, input int unsigned cnt, input bit gaps);
    logic [15:0] exp;
    exp = model_read(rg);
    wr(hdr(2'b01, rg, 5'(cnt)));
    idle_r();
    for (int w = 0; w < int'(cnt); w++) begin
      if (gaps && $urandom_range(0, 2) == 0) idle_r();
      drive(1'b0, 1'b1, 16'($urandom));
      check("rd_busy_set", busy, 1'b1);
      for (int k = 1; k <= int'(BusyCycles); k++) begin
        if (gaps && $urandom_range(0, 2) == 0) begin
          idle_r();
          check("rd_busy_pause", busy, 1'b1);
        end
        drive(1'b0, 1'b1, 16'($urandom));
        if (k < int'(BusyCycles)) begin
          check("rd_busy_hold", busy, 1'b1);
        end else begin
          check("rd_busy_clear", busy, 1'b0);
          check("rd_dout", dout, swap16(exp));
        end
      end
    end
    idle_r();
    check("rd_dout_hold", dout, swap16(exp));
    check("rd_synced", synced, m_synced);
  endtask

  task automatic do_reboot();
    wr(16'h30A1);
    wr(16'h000E);
    m_synced = 1'b0;
    check("reboot_pulse", reboot, 1'b1);
    check("reboot_addr", boot_addr, {m_gen2[7:0], m_gen1});
    check("reboot_synced", synced, 1'b0);
    check("reboot_gen5", gen5, m_gen5);
    idle_w();
    check("reboot_once", reboot, 1'b0);
  endtask

  initial begin
    logic [5:0]  regs [4];
    logic [15:0] bad;
    int unsigned t;
    regs = '{6'h13, 6'h14, 6'h17, 6'h0A};

    reset = 1'b1;
    ce    = 1'b1;
    write = 1'b0;
    din   = 16'h0000;
    model_reset();
    #2;
    check("rst_dout", dout, 16'hFFFF);
    check("rst_busy", busy, 1'b0);
    check("rst_synced", synced, 1'b0);
    check("rst_reboot", reboot, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_boot_addr", boot_addr, 24'h0);
    check("rst_gen5", gen5, Gen5Init);
    @(posedge clk_16M00);
    @(negedge clk_16M00);
    reset = 1'b0;

    // Readback of the power-on GENERAL_5 value through NOOPs
    do_sync();
    wr(16'h2AE1);
    wr(16'h2000);
    wr(16'h2000);
    idle_r();
    drive(1'b0, 1'b1, 16'h0);
    check("rb_busy1", busy, 1'b1);
    drive(1'b0, 1'b1, 16'h0);
    check("rb_busy2", busy, 1'b1);
    drive(1'b0, 1'b1, 16'h0);
    check("rb_busy_done", busy, 1'b0);
    check("rb_dout", swap16(dout), 16'h00A5);
    idle_r();
    idle_w();

    // Desync, then a GEN1 write that must be ignored
    wr(16'h30A1);
    wr(16'h000D);
    m_synced = 1'b0;
    check("desync_synced", synced, 1'b0);
    wr(16'h3261);
    wr(16'h1234);
    check("desync_gen1", boot_addr, {m_gen2[7:0], m_gen1});
    check("desync_still", synced, 1'b0);

    // Multiboot sequence
    wr(16'hFFFF);
    check("mb_ffff_ignored", synced, 1'b0);
    do_sync();
    wr(16'h3261); wr(16'h4000); m_gen1 = 16'h4000;
    wr(16'h3281); wr(16'h0305); m_gen2 = 16'h0305;
    wr(16'h32E1); wr(16'h0053); m_gen5 = 16'h0053;
    do_reboot();
    check("mb_addr_const", boot_addr, 24'h054000);

    // Abort: mode change without a CE-high bracket
    do_sync();
    wr(16'h2AE1);
    drive(1'b0, 1'b1, 16'h0);
    m_synced = 1'b0;
    check("abort_error", error, 1'b1);
    check("abort_synced", synced, 1'b0);
    check("abort_busy", busy, 1'b0);
    drive(1'b0, 1'b1, 16'h0);
    check("abort_error_once", error, 1'b0);
    check("abort_busy_after", busy, 1'b0);
    idle_r();

    // GEN5 retention across REBOOT
    do_sync();
    wr(16'h32E1); wr(16'h0011); m_gen5 = 16'h0011;
    do_reboot();
    do_sync();
    read_pkt(6'h17, 1, 1'b0);
    check("ret_gen5", gen5, 16'h0011);

    // Asynchronous reset in the middle of a read
    wr(16'h2AE1);
    idle_r();
    drive(1'b0, 1'b1, 16'h0);
    check("mid_busy", busy, 1'b1);
    @(negedge clk_16M00);
    reset = 1'b1;
    ce    = 1'b1;
    #1;
    model_reset();
    check("arst_busy", busy, 1'b0);
    check("arst_gen5", gen5, Gen5Init);
    check("arst_synced", synced, 1'b0);
    check("arst_boot_addr", boot_addr, 24'h0);
    @(posedge clk_16M00);
    @(negedge clk_16M00);
    reset = 1'b0;

    // Sync edge cases
    wr(16'hAA99); wr(16'h1234); wr(16'h5566);
    check("sync_broken", synced, 1'b0);
    wr(16'hAA99); wr(16'hAA99); wr(16'h5566);
    m_synced = 1'b1;
    check("sync_repeat", synced, 1'b1);
    wr(16'h5000);
    check("type2_error", error, 1'b1);
    check("type2_synced", synced, 1'b1);
    idle_w();
    check("type2_error_once", error, 1'b0);

    // Randomized packet traffic
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: write_pkt(regs[$urandom_range(0, 3)], $urandom_range(1, 3));
        4, 5, 6:    read_pkt(regs[$urandom_range(0, 3)], $urandom_range(1, 2), 1'b1);
        7: begin
          wr(hdr(2'b00, 6'($urandom), 5'($urandom)));
          check("noop_error", error, 1'b0);
          check("noop_synced", synced, m_synced);
        end
        8: begin
          t = $urandom_range(0, 6);
          if (t >= 1) t = t + 1;
          bad = {3'(t), 13'($urandom)};
          wr(bad);
          check("bad_hdr_error", error, 1'b1);
          check("bad_hdr_synced", synced, m_synced);
        end
        default: begin
          do_reboot();
          do_sync();
        end
      endcase
      if ($urandom_range(0, 1) == 0) idle_w();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/icap_responder.md
# icap_responder

Synthesizable model of the Spartan-6 ICAP configuration-packet port, the far end of the multiboot controller. It sits on the bit-reversed 16-bit ICAP bus in place of the primitive, in simulation and on targets without ICAP. It decodes sync words and type-1 packets, holds GENERAL_1/2/5, and answers GENERAL_5 reads with the BUSY handshake. On REBOOT it emits a pulse with the latched boot address.

## Interface
- `BUSY_CYCLES`, default 2: read-mode cycles with `busy`=1 before each read word (1..15).
- `GEN5_INIT`, default 16'h0000: GENERAL_5 power-on value; models soft-dip retention across reboot.
- `clk_16M00` in 1: single clock; all logic on posedge.
- `reset` in 1: asynchronous, active-high.
- `ce` in 1: ICAP CE, active-low.
- `write` in 1: 0 = write, 1 = read (ICAP WRITE).
- `din` in 16: bit-reversed write data.
- `dout` out 16: bit-reversed read data.
- `busy` out 1: read data not yet valid.
- `synced` out 1: sync word accepted.
- `reboot` out 1: one-cycle pulse on REBOOT command.
- `boot_addr` out 24: {GEN2[7:0], GEN1[15:0]}, valid with `reboot`.
- `gen5` out 16: current GENERAL_5.
- `error` out 1: one-cycle pulse on abort or unsupported packet.

## Operation
- Bus words are de-reversed on input; read words are reversed on output, bits [7:0] and [15:8] each mirrored within the byte. All decoding below uses logical values.
- A word is consumed only when `ce`=0 and `write`=0. Other cycles are idle, except for the read-mode rules below.
- **Header** fields: [15:13] type, [12:11] op (00 NOOP, 01 read, 10 write), [10:5] register, [4:0] count.
- **Registers**: CMD=0x05, GEN1=0x13, GEN2=0x14, GEN5=0x17.
- **Commands**: REBOOT=0x000E, DESYNC=0x000D.
- States:
  - UNSYNC: word 0xAA99 goes to SYNC1. Everything else is ignored, including 0xFFFF.
  - SYNC1: 0x5566 goes to HDR and sets `synced`. 0xAA99 stays in SYNC1. Anything else goes to UNSYNC.
  - HDR: type≠001 pulses `error` and stays in HDR. NOOP stays in HDR. Write with count>0 goes to WDATA. Read with count>0 goes to RWAIT. Count 0 stays in HDR.
  - WDATA: each word decrements count. GEN1/2/5 store the word; the last word wins. CMD writes take effect per word:
    - REBOOT pulses `reboot` next cycle, then UNSYNC.
    - DESYNC goes to UNSYNC.
    - Other codes are ignored.
  - Writes to other registers are discarded. At count 0, return to HDR.
  - RWAIT: write-mode words are ignored. The first read-mode cycle (`ce`=0, `write`=1) goes to RBUSY.
  - RBUSY: `busy`=1 for BUSY_CYCLES read-mode cycles. Then `dout` = register value, `busy`=0, and count decrements.
    - Register values: GEN1/GEN2/GEN5 as stored; others read 0x0000.
    - Count>0 re-enters RBUSY on the next read-mode cycle. Count 0 goes to RDONE.
  - RDONE: wait for a write-mode word, which is decoded as a header in HDR.
- **Abort**: `write` toggling while `ce`=0 on consecutive cycles. Response: pulse `error`, clear `synced`, go to UNSYNC. The CE-high bracketing cycle around a mode change is therefore mandatory for initiators.
- **Retention**: GEN1/GEN2 clear to 0 on `reset`. GEN5 loads GEN5_INIT on `reset` only and is never cleared by REBOOT or DESYNC.

## Timing
- Reset values:
  - `dout`=16'hFFFF, `busy`=0, `synced`=0, `reboot`=0, `error`=0.
  - `boot_addr`=0, `gen5`=GEN5_INIT, state UNSYNC.
- All outputs are registered.
- Header or data sampled at edge N; register update visible at N+1.
- `reboot` high for exactly cycle N+1 after the REBOOT word at edge N. `synced` falls at the same edge.
- Read: the first read-mode edge R sets `busy` at R+1. `busy` falls and `dout` is valid at R+1+BUSY_CYCLES. `dout` holds until the next read word or reset.
- In RBUSY, `ce`=1 cycles pause the busy count without abort.
- Reset mid-packet or mid-read: immediate return to UNSYNC; `busy` drops asynchronously.

## Structure
- Shared package `icap_pkg`:
  - sync words 0xAA99/0x5566, NOOP 0x2000, opcodes, register addresses, CMD codes
  - state enum
  - header field slices
- Sub-module `icap_bitswap`: combinational per-byte bit reversal, instanced on `din` and `dout`. The multiboot controller reuses it.

## Test plan
- **Multiboot**: feed FFFF,AA99,5566,3261,4000,3281,0305,32E1,0053,30A1,000E (raw reversed) -> `reboot` pulse, `boot_addr`=24'h054000, `gen5`=0x0053, `synced`=0.
- **Readback**: GEN5_INIT=0x00A5; sync, 2AE1, NOOPs, CE-high cycle, read mode -> `busy` for 2 cycles, then logical `dout`=0x00A5.
- **Desync**: sync, 30A1,000D, then 3261,1234 -> GEN1 stays 0, `synced`=0.
- **Abort**: `write` 0→1 with `ce` held 0 after a 2AE1 -> `error` pulse, UNSYNC, `busy` never asserted.
- **Retention and reset**: REBOOT after GEN5=0x0011, then re-sync and read -> 0x0011. Assert `reset` during RBUSY -> `busy`=0, `gen5`=GEN5_INIT.
- **Sync edge cases**: type-2 header 0x5000 -> `error` pulse, still synced. Sequence AA99,AA99,5566 -> synced.
